// File: rtl/aes_dec_stream_ctrl.sv
// Streaming controller around a pipelined AES-128 decryption core: key sequencing,
// pipeline validity tracking and a credit-protected show-ahead output FIFO.
module aes_dec_stream_ctrl #(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned PIPE_LAT     = 11,
  parameter int unsigned KEY_LAT      = 11,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BLOCK_LENGTH-1:0] key_in,
  input  logic                    key_load,
  output logic                    key_ready,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [BLOCK_LENGTH-1:0] s_data,
  output logic [BLOCK_LENGTH-1:0] core_key,
  output logic                    core_fsm_en,
  output logic                    core_enable,
  output logic [BLOCK_LENGTH-1:0] core_in,
  input  logic [BLOCK_LENGTH-1:0] core_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [BLOCK_LENGTH-1:0] m_data,
  output logic                    busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned KcW  = $clog2(KEY_LAT + 1);

  localparam logic [CntW:0]  CreditMax = FIFO_DEPTH[CntW:0];
  localparam logic [CntW-1:0] FifoFull = FIFO_DEPTH[CntW-1:0];
  localparam logic [KcW-1:0]  KcLast   = KcW'(KEY_LAT - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StKeyExp = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;
  localparam logic [1:0] StDrain  = 2'd3;

  logic [1:0]              state_q, state_d;
  logic [KcW-1:0]          kcnt_q, kcnt_d;
  logic [BLOCK_LENGTH-1:0] core_key_q, core_key_d;
  logic [BLOCK_LENGTH-1:0] pend_key_q, pend_key_d;
  logic                    pend_q, pend_d;
  logic [PIPE_LAT-1:0]     vld_sr_q, vld_sr_d;
  logic [CntW-1:0]         in_flight_q, in_flight_d;
  logic [CntW-1:0]         fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [BLOCK_LENGTH-1:0] mem_q [FIFO_DEPTH];
  logic [CntW:0]           credit_used;
  logic                    push, pop;

  // Credit covers both blocks still in the core and blocks already buffered.
  assign credit_used = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q};
  assign key_ready   = (state_q == StRun);
  assign s_ready     = key_ready && (credit_used < CreditMax);
  assign core_enable = s_valid && s_ready;
  assign core_in     = s_data;
  assign core_key    = core_key_q;
  assign core_fsm_en = (state_q == StKeyExp) && (kcnt_q == '0);

  assign push    = vld_sr_q[PIPE_LAT-1];
  assign m_valid = (fifo_cnt_q != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem_q[rd_ptr_q];
  assign busy    = (in_flight_q != '0) || (fifo_cnt_q != '0);

  always_comb begin
    state_d    = state_q;
    kcnt_d     = kcnt_q;
    core_key_d = core_key_q;
    pend_key_d = pend_key_q;
    pend_d     = pend_q;
    unique case (state_q)
      StIdle: begin
        if (key_load) begin
          state_d    = StKeyExp;
          kcnt_d     = '0;
          core_key_d = key_in;
          pend_d     = 1'b0;
        end
      end
      StKeyExp: begin
        // A running expansion is never restarted; a new key waits for it to finish.
        if (key_load) begin
          pend_d     = 1'b1;
          pend_key_d = key_in;
        end
        if (kcnt_q == KcLast) begin
          state_d = (pend_q || key_load) ? StDrain : StRun;
        end else begin
          kcnt_d = kcnt_q + KcW'(1);
        end
      end
      StRun: begin
        if (key_load) begin
          state_d    = StDrain;
          pend_d     = 1'b1;
          pend_key_d = key_in;
        end
      end
      StDrain: begin
        if (key_load) begin
          pend_key_d = key_in;
        end
        if (in_flight_q == '0) begin
          state_d    = StKeyExp;
          kcnt_d     = '0;
          core_key_d = key_load ? key_in : pend_key_q;
          pend_d     = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    vld_sr_d    = {vld_sr_q[PIPE_LAT-2:0], core_enable};
    in_flight_d = in_flight_q + CntW'(core_enable) - CntW'(push);
    fifo_cnt_d  = fifo_cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      kcnt_q      <= '0;
      core_key_q  <= '0;
      pend_key_q  <= '0;
      pend_q      <= 1'b0;
      vld_sr_q    <= '0;
      in_flight_q <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      core_key_q  <= core_key_d;
      pend_key_q  <= pend_key_d;
      pend_q      <= pend_d;
      vld_sr_q    <= vld_sr_d;
      in_flight_q <= in_flight_d;
      fifo_cnt_q  <= fifo_cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= core_out;
    end
  end

  // Credit gating makes a write into a full FIFO impossible.
  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (fifo_cnt_q == FifoFull)));

endmodule

// File: tb/tb_aes_dec_stream_ctrl.sv
// Self-checking bench for aes_dec_stream_ctrl with a behavioural AES-128 decryption core.
module tb_aes_dec_stream_ctrl;

  localparam int unsigned PIPE_LAT   = 11;
  localparam int unsigned KEY_LAT    = 11;
  localparam int unsigned FIFO_DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in, s_data, core_key, core_in, m_data;
  logic [127:0] core_out = '0;
  logic         key_load, key_ready, s_valid, s_ready, core_fsm_en, core_enable;
  logic         m_valid, m_ready, busy;

  always #5 clk = ~clk;

  aes_dec_stream_ctrl #(
    .BLOCK_LENGTH(128),
    .PIPE_LAT    (PIPE_LAT),
    .KEY_LAT     (KEY_LAT),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_load   (key_load),
    .key_ready  (key_ready),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .core_key   (core_key),
    .core_fsm_en(core_fsm_en),
    .core_enable(core_enable),
    .core_in    (core_in),
    .core_out   (core_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .busy       (busy)
  );

  // ---------------- AES-128 inverse cipher model ----------------
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] rk, res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8];
    for (int r = 10; r >= 0; r--) begin
      rk = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      if (r != 10) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++) u[4*c+j] = isb[s[4*((c-j+4)%4)+j]];
        s = u;
      end
      for (int i = 0; i < 16; i++) s[i] ^= rk[127-8*i -: 8];
      if (r != 0 && r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
          s[4*c+1] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
          s[4*c+2] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
          s[4*c+3] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Core model: round keys taken at the expansion pulse, applied when a block leaves.
  logic [127:0] pipe [PIPE_LAT-1];
  logic [127:0] model_key = '0;
  int           exp_cnt = 0;
  int           bad_inj = 0;

  always @(posedge clk) begin
    pipe[0] <= core_in;
    for (int i = 1; i < int'(PIPE_LAT) - 1; i++) pipe[i] <= pipe[i-1];
    core_out <= aes_dec(pipe[PIPE_LAT-2], model_key);
    if (core_fsm_en) begin
      model_key <= core_key;
      exp_cnt   <= KEY_LAT - 1;
    end else if (exp_cnt > 0) begin
      exp_cnt <= exp_cnt - 1;
    end
    if (core_enable && (exp_cnt != 0 || core_fsm_en)) bad_inj <= bad_inj + 1;
  end

  // ---------------- checking ----------------
  int           n_chk = 0, n_fail = 0;
  int           n_acc = 0, n_pop = 0;
  int           cyc = 0, last_pop = -10, run_len = 0;
  logic [127:0] cur_key = '0;
  logic [127:0] exp_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Scoreboard: expected plaintext queued at acceptance, compared at pop.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      if (s_valid && s_ready) begin
        exp_q.push_back(aes_dec(s_data, cur_key));
        n_acc++;
      end
      if (m_valid && m_ready) begin
        n_pop++;
        run_len  = (cyc == last_pop + 1) ? run_len + 1 : 1;
        last_pop = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexpected: got %h, expected no output", m_data);
        end else begin
          check("out_data", m_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // key_load is raised in the caller's current cycle t; returns at the negedge of
  // the first key_ready cycle, checking its distance from t.
  task automatic load_key(input logic [127:0] k, input int exp_lat);
    int n, pulses, early;
    key_in = k; key_load = 1'b1;
    step();
    key_load = 1'b0;
    n = 1; pulses = 0; early = 0;
    while (n < 80) begin
      @(negedge clk);
      if (core_fsm_en) pulses++;
      if (key_ready) break;
      if (s_ready) early++;
      step();
      n++;
    end
    check_int("key_latency", n, exp_lat);
    check_int("key_fsm_en_pulses", pulses, 1);
    check_int("key_s_ready_early", early, 0);
    cur_key = k;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      if (!busy) break;
      step();
      n++;
    end
    check_bit(name, busy, 1'b0);
  endtask

  task automatic hold_stream(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      step();
      if (acc) s_data = rnd();
    end
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
    int           key_lat;
    int           blk_lat;
  } kat_t;

  kat_t         kat [2];
  int           n, lat, stalls, acc0, pop0, pulses, seen;
  logic [127:0] k1, k2;

  initial begin
    rst = 1'b0; key_in = '0; key_load = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    // From IDLE: 12 cycles to RUN; from RUN with nothing in flight: one DRAIN cycle more.
    kat[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
               128'h00112233445566778899aabbccddeeff, 12, 12};
    kat[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
               128'h3243f6a8885a308d313198a2e0370734, 13, 12};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_bit("rst_s_ready", s_ready, 1'b0);
    check_bit("rst_key_ready", key_ready, 1'b0);
    check_bit("rst_core_fsm_en", core_fsm_en, 1'b0);
    check_bit("rst_core_enable", core_enable, 1'b0);
    check("rst_core_key", core_key, '0);
    check_bit("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, '0);
    check_bit("rst_busy", busy, 1'b0);
    step();
    rst = 1'b1;

    // Known-answer vectors
    for (int v = 0; v < 2; v++) begin
      step();
      load_key(kat[v].key, kat[v].key_lat);
      step();
      s_data = kat[v].ct; s_valid = 1'b1;
      @(negedge clk);
      check_bit("kat_accept", s_ready, 1'b1);
      step();
      s_valid = 1'b0;
      lat = 1;
      while (lat <= 40) begin
        @(negedge clk);
        if (m_valid) break;
        step();
        lat++;
      end
      check_int("kat_latency", lat, kat[v].blk_lat);
      check("kat_plaintext", m_data, kat[v].pt);
    end

    // 32 back-to-back blocks
    step();
    stalls = 0; pop0 = n_pop;
    for (int i = 0; i < 32; i++) begin
      s_data = rnd(); s_valid = 1'b1;
      @(negedge clk);
      if (!s_ready) stalls++;
      step();
    end
    s_valid = 1'b0;
    check_int("stream_stalls", stalls, 0);
    wait_idle("stream_idle");
    check_int("stream_pops", n_pop - pop0, 32);
    check_int("stream_consecutive", run_len, 32);

    // Backpressure: exactly FIFO_DEPTH credits
    step();
    m_ready = 1'b0; acc0 = n_acc; pop0 = n_pop;
    s_data = rnd(); s_valid = 1'b1;
    hold_stream(40);
    @(negedge clk);
    check_int("bp_accepted", n_acc - acc0, FIFO_DEPTH);
    check_bit("bp_s_ready_low", s_ready, 1'b0);
    check_bit("bp_m_valid", m_valid, 1'b1);
    step();
    m_ready = 1'b1;
    @(negedge clk);
    check_bit("bp_no_credit_same_cycle", s_ready, 1'b0);
    step();
    @(negedge clk);
    check_bit("bp_credit_returned", s_ready, 1'b1);
    step();
    s_data = rnd();
    hold_stream(20);
    s_valid = 1'b0;
    wait_idle("bp_idle");
    check_int("bp_no_loss_dup", n_pop - pop0, n_acc - acc0);
    check_int("bp_queue_empty", exp_q.size(), 0);

    // Key change after 5 blocks: DRAIN until the last one leaves (t+11), then 11 of KEY_EXP
    step();
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      s_data = rnd(); s_valid = 1'b1;
      @(negedge clk);
      if (!s_ready) stalls++;
      step();
    end
    s_valid = 1'b0;
    check_int("kc_old_accepts", stalls, 0);
    load_key(128'hfedcba98765432100123456789abcdef, 23);
    step();
    for (int i = 0; i < 5; i++) begin
      s_data = rnd(); s_valid = 1'b1;
      @(negedge clk);
      step();
    end
    s_valid = 1'b0;
    wait_idle("kc_idle");
    check_int("kc_queue_empty", exp_q.size(), 0);

    // Two loads during an expansion: finish, DRAIN, re-expand with the last key
    step();
    key_in = 128'h11111111111111111111111111111111; key_load = 1'b1;
    pulses = 0; n = 0; k1 = '0; k2 = '0;
    while (n < 80) begin
      step();
      n++;
      key_load = (n == 3) || (n == 4);
      key_in   = (n == 3) ? 128'h22222222222222222222222222222222
                          : 128'h33333333333333333333333333333333;
      @(negedge clk);
      if (core_fsm_en) begin
        pulses++;
        if (pulses == 1) k1 = core_key;
        else k2 = core_key;
      end
      if (key_ready) break;
    end
    key_load = 1'b0;
    check_int("dbl_latency", n, 25);
    check_int("dbl_fsm_en_pulses", pulses, 2);
    check("dbl_first_key", k1, 128'h11111111111111111111111111111111);
    check("dbl_second_key", k2, 128'h33333333333333333333333333333333);
    cur_key = 128'h33333333333333333333333333333333;
    step();
    for (int i = 0; i < 3; i++) begin
      s_data = rnd(); s_valid = 1'b1;
      @(negedge clk);
      step();
    end
    s_valid = 1'b0;
    wait_idle("dbl_idle");
    check_int("dbl_queue_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a backpressured stream
    step();
    m_ready = 1'b0; s_data = rnd(); s_valid = 1'b1;
    hold_stream(14);
    @(negedge clk);
    check_bit("pre_rst_m_valid", m_valid, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_bit("mid_rst_s_ready", s_ready, 1'b0);
    check_bit("mid_rst_key_ready", key_ready, 1'b0);
    check_bit("mid_rst_core_enable", core_enable, 1'b0);
    check_bit("mid_rst_m_valid", m_valid, 1'b0);
    check("mid_rst_m_data", m_data, '0);
    check("mid_rst_core_key", core_key, '0);
    check_bit("mid_rst_busy", busy, 1'b0);
    exp_q.delete();
    step();
    rst = 1'b1; m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (m_valid || s_ready) seen++;
      step();
    end
    s_valid = 1'b0;
    check_int("post_rst_quiet", seen, 0);
    check_int("inject_during_keyexp", bad_inj, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_dec_stream_ctrl.md
# aes_dec_stream_ctrl

Streaming front/back-end controller wrapped around the pipelined AES-128 decryption core. Upstream, it accepts ciphertext blocks over a valid/ready interface. It sequences key expansion in the core and only injects blocks into the core's 11-stage pipeline once the round keys are valid. Downstream, it recovers per-block validity from the fixed pipeline latency and buffers plaintext in an output FIFO, exposed over a valid/ready interface with credit-based backpressure.

## Interface
- BLOCK_LENGTH, 128, data/key width
- PIPE_LAT, 11, cycles from core_enable=1 (block presented) to core_out holding that block's plaintext
- KEY_LAT, 11, cycles from the core_fsm_en pulse to all round keys valid
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- key_in  in  128  cipher key, sampled on key_load
- key_load  in  1  one-cycle request to install key_in
- key_ready  out  1  round keys valid, stream accepting
- s_valid  in  1  ciphertext valid
- s_ready  out  1  ciphertext accepted when s_valid&&s_ready
- s_data  in  128  ciphertext block
- core_key  out  128  key to core, held stable between loads
- core_fsm_en  out  1  one-cycle key-expansion start pulse to core
- core_enable  out  1  block-injection strobe to core
- core_in  out  128  block to core (=s_data)
- core_out  in  128  plaintext from core last stage
- m_valid  out  1  plaintext available
- m_ready  in  1  downstream accepts
- m_data  out  128  plaintext block (FIFO head)
- busy  out  1  blocks in flight or FIFO non-empty

## Operation
- States:
  - IDLE: no key. s_ready=0.
  - KEY_EXP: counting KEY_LAT.
  - RUN: accepting blocks.
  - DRAIN: key change pending; no injection.
- Transitions:
  - IDLE + key_load → KEY_EXP. key_in→core_key; core_fsm_en=1 on the first KEY_EXP cycle only.
  - KEY_EXP, counter reaches KEY_LAT → RUN, or → DRAIN if a key is pending.
  - RUN + key_load → DRAIN; key_in latched into pending_key.
  - DRAIN with in_flight==0 → KEY_EXP; pending_key→core_key.
- key_load in KEY_EXP or DRAIN overwrites pending_key (last write wins). Expansion in progress is never restarted.
- core_key changes only on entry to KEY_EXP. In-flight blocks always complete with the key they entered with.
- Validity tracking:
  - PIPE_LAT-bit shift register vld_sr, shifted every cycle; bit0 = core_enable.
  - When the tail bit is 1, core_out is written to the FIFO that cycle.
  - in_flight = popcount(vld_sr), held as a counter.
- Credit: s_ready = (state==RUN) && (in_flight + fifo_count < FIFO_DEPTH). The FIFO can therefore never overflow; a write when full is a design error (assertion).
- core_enable = s_valid && s_ready. core_in = s_data combinationally.
- FIFO: show-ahead. m_data = head, m_valid = fifo_count≠0, pop on m_valid&&m_ready. Simultaneous push and pop in one cycle leaves the count unchanged.
- key_ready = (state==RUN).
- busy = (in_flight≠0) || (fifo_count≠0).
- Width rules: in_flight and fifo_count are each log2(FIFO_DEPTH)+1 bits; their sum is computed at +1 bit. Pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: s_ready=0, key_ready=0, core_fsm_en=0, core_enable=0, core_key=0, m_valid=0, m_data=0 (FIFO storage cleared), busy=0. State=IDLE; vld_sr, counters, and pointers are all 0.
- Reset mid-operation: everything is cleared immediately. In-flight and buffered blocks are discarded, and no m_valid is produced afterwards until a new key is loaded and new blocks are sent.
- key_load at cycle t (IDLE):
  - core_fsm_en=1 at t+1.
  - RUN and key_ready=1 at t+1+KEY_LAT; the first block is accepted no earlier than then.
- Block accepted at cycle c: written to the FIFO at the c+PIPE_LAT edge; m_valid=1 from c+PIPE_LAT+1. Minimum end-to-end latency is PIPE_LAT+1.
- Throughput: one block per cycle sustained while m_ready=1.
- Ordering: output order equals input order.
- Backpressure: with m_ready=0, s_ready falls in the cycle that in_flight+fifo_count reaches FIFO_DEPTH. A pop frees one credit the following cycle.

## Test plan
- Reset: assert rst mid-stream → all outputs at reset values within the same cycle; the FIFO stays empty after release.
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, s_data 69c4e0d86a7b0430d8cdb78070b4c55a accepted at cycle c → m_data 00112233445566778899aabbccddeeff with m_valid at c+12.
- Streaming: 32 back-to-back blocks, m_ready=1 → s_ready stays 1 throughout; 32 plaintexts on consecutive cycles, in order, matching the reference model.
- Backpressure: m_ready=0, s_valid=1 held → exactly 16 blocks accepted, then s_ready=0; release m_ready → all 16 out in order, then acceptance resumes. No loss, no duplicates.
- Key change mid-stream: key_load after 5 blocks → those 5 decrypt under the old key. s_ready stays 0 through DRAIN plus KEY_LAT, with core_fsm_en pulsing exactly once; subsequent blocks decrypt under the new key.
- Double key_load during KEY_EXP → after the current expansion: DRAIN, then a second expansion using the last loaded key.
